fetch_bundle_queue: RTL

FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

---
 rtl/fetch_bundle_queue_pkg.sv | 18 +
 rtl/fetch_queue_ram.sv | 26 ++
 rtl/fetch_bundle_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_bundle_queue_pkg.sv
// Shared fetch-stage constants: PC/bundle widths, queue depth and the
// packed bit layout of one fetch queue entry.
package fetch_bundle_queue_pkg;

   localparam int unsigned SIZE_PC            = 32;
   localparam int unsigned INSTRUCTION_BUNDLE = 4 * 32;
   localparam int unsigned FQ_DEPTH           = 4;

   // Entry layout, MSB to LSB: bundle, pc, rasCP, targets, btbHit, prediction.
   localparam int unsigned FQ_PRED_LSB   = 0;
   localparam int unsigned FQ_BTB_LSB    = FQ_PRED_LSB + 4;
   localparam int unsigned FQ_TGT_LSB    = FQ_BTB_LSB + 4;
   localparam int unsigned FQ_RAS_LSB    = FQ_TGT_LSB + 4 * SIZE_PC;
   localparam int unsigned FQ_PC_LSB     = FQ_RAS_LSB + SIZE_PC;
   localparam int unsigned FQ_BUNDLE_LSB = FQ_PC_LSB + SIZE_PC;
   localparam int unsigned FQ_ENTRY_W    = FQ_BUNDLE_LSB + INSTRUCTION_BUNDLE;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fetch_queue_ram #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ENTRY_W = 8,
   parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [ENTRY_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [ENTRY_W-1:0] rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Decoupling queue between fetch stage 1 and decode. Full-ness is decoded
// from the registered count only, so back-pressure never depends on deqReady_i.
module fetch_bundle_queue
   import fetch_bundle_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = FQ_DEPTH,
   parameter int unsigned ENTRY_W = INSTRUCTION_BUNDLE + 6 * SIZE_PC + 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush_i,
   input  logic                          fs1Ready_i,
   input  logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_i,
   input  logic [SIZE_PC-1:0]            pc_i,
   input  logic [SIZE_PC-1:0]            addrRAS_CP_i,
   input  logic [3:0]                    btbHit_i,
   input  logic [3:0]                    prediction_i,
   input  logic [4*SIZE_PC-1:0]          targetAddr_i,
   output logic                          stall_o,
   input  logic                          deqReady_i,
   output logic                          valid_o,
   output logic [INSTRUCTION_BUNDLE-1:0] instructionBundle_o,
   output logic [SIZE_PC-1:0]            pc_o,
   output logic [SIZE_PC-1:0]            addrRAS_CP_o,
   output logic [3:0]                    btbHit_o,
   output logic [3:0]                    prediction_o,
   output logic [4*SIZE_PC-1:0]          targetAddr_o,
   output logic [$clog2(DEPTH):0]        occupancy_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [PtrW-1:0]    head_q, head_d;
   logic [PtrW-1:0]    tail_q, tail_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               enq, deq;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] rd_data;

   assign stall_o     = (count_q == FullCnt);
   assign valid_o     = (count_q != '0);
   assign occupancy_o = count_q;

   assign enq = fs1Ready_i & ~stall_o & ~flush_i;
   assign deq = valid_o & deqReady_i & ~flush_i;

   assign wr_data = {instructionBundle_i, pc_i, addrRAS_CP_i, targetAddr_i, btbHit_i,
                     prediction_i};

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + PtrW'(1);
         if (deq) head_d = head_q + PtrW'(1);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Gate the write with reset so an edge seen while in reset stores nothing.
   fetch_queue_ram #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W),
      .ADDR_W  (PtrW)
   ) u_ram (
      .clk     (clk),
      .we_i    (enq & reset),
      .waddr_i (tail_q),
      .wdata_i (wr_data),
      .raddr_i (head_q),
      .rdata_o (rd_data)
   );

   assign instructionBundle_o = rd_data[FQ_BUNDLE_LSB +: INSTRUCTION_BUNDLE];
   assign pc_o                = rd_data[FQ_PC_LSB +: SIZE_PC];
   assign addrRAS_CP_o        = rd_data[FQ_RAS_LSB +: SIZE_PC];
   assign targetAddr_o        = rd_data[FQ_TGT_LSB +: 4 * SIZE_PC];
   assign btbHit_o            = rd_data[FQ_BTB_LSB +: 4];
   assign prediction_o        = rd_data[FQ_PRED_LSB +: 4];

endmodule
